// File: rtl/issue_scoreboard_if.sv
// Signal bundle for issue_scoreboard: decoded beat in, issued beat out,
// writeback / branch-resolve completions and the sticky error mask.
interface issue_scoreboard_if;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [4:0]  warp_id_in;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [7:0]  opcode;
  logic [31:0] imm;
  logic [7:0]  feature_flags;

  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [4:0]  m_warp_id;
  logic [4:0]  m_rd;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;
  logic [7:0]  m_opcode;
  logic [31:0] m_imm;
  logic [7:0]  m_feature_flags;

  logic        wb_valid;
  logic [4:0]  wb_warp_id;
  logic [4:0]  wb_rd;

  logic        br_valid;
  logic [4:0]  br_warp_id;

  logic [31:0] err;

  // Handshake: a beat transfers on the issue side in any cycle where
  // m_tvalid & m_tready; m_* hold stable while m_tvalid=1 and m_tready=0.
  // s_tvalid is never stalled: s_tready is only a throttle hint to fetch.
  modport master (
    output s_tvalid, s_tlast, warp_id_in, rd, rs1, rs2, opcode, imm, feature_flags,
    input  s_tready,
    input  m_tvalid, m_tlast, m_warp_id, m_rd, m_rs1, m_rs2, m_opcode, m_imm,
           m_feature_flags,
    output m_tready,
    output wb_valid, wb_warp_id, wb_rd,
    output br_valid, br_warp_id,
    input  err
  );

  modport slave (
    input  s_tvalid, s_tlast, warp_id_in, rd, rs1, rs2, opcode, imm, feature_flags,
    output s_tready,
    output m_tvalid, m_tlast, m_warp_id, m_rd, m_rs1, m_rs2, m_opcode, m_imm,
           m_feature_flags,
    input  m_tready,
    input  wb_valid, wb_warp_id, wb_rd,
    input  br_valid, br_warp_id,
    output err
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue buffer with a per-warp register busy scoreboard and branch gating.
// Optional KIANA_SP_SCOREBOARD_BYPASS_EN lets same-cycle wb/br clears release the head.
module issue_scoreboard #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_scoreboard_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        tlast;
    logic [4:0]  warp;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [7:0]  opcode;
    logic [31:0] imm;
    logic [7:0]  flags;
  } beat_t;

  beat_t             r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [31:0][31:0] r_busy;
  logic [31:0]       r_br_pend;
  logic [2:0]        r_err;

  beat_t       w_in;
  beat_t       w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_hazard;
  logic        w_valid;
  logic [31:0] w_busy_row;
  logic        w_pend;

  // Indices 0 and 31 mean "no operand" and never touch the scoreboard.
  function automatic logic is_reg(input logic [4:0] idx);
    return (idx != 5'd0) && (idx != 5'd31);
  endfunction

  always_comb begin
    w_in        = '0;
    w_in.tlast  = bus.s_tlast;
    w_in.warp   = bus.warp_id_in;
    w_in.rd     = bus.rd;
    w_in.rs1    = bus.rs1;
    w_in.rs2    = bus.rs2;
    w_in.opcode = bus.opcode;
    w_in.imm    = bus.imm;
    w_in.flags  = bus.feature_flags;
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));

  always_comb begin
    w_head        = '0;
    w_head.opcode = 8'hff;
    if (!w_empty) w_head = r_mem[r_rd_ptr];
  end

  always_comb begin
    w_busy_row = r_busy[w_head.warp];
    w_pend     = r_br_pend[w_head.warp];
`ifdef KIANA_SP_SCOREBOARD_BYPASS_EN
    if (bus.wb_valid && (bus.wb_warp_id == w_head.warp)) w_busy_row[bus.wb_rd] = 1'b0;
    if (bus.br_valid && (bus.br_warp_id == w_head.warp)) w_pend = 1'b0;
`endif
    w_hazard = w_pend
             | (is_reg(w_head.rs1) & w_busy_row[w_head.rs1])
             | (is_reg(w_head.rs2) & w_busy_row[w_head.rs2])
             | (is_reg(w_head.rd)  & w_busy_row[w_head.rd]);
  end

  assign w_valid = !w_empty && !w_hazard;
  assign w_pop   = w_valid && bus.m_tready;
  assign w_push  = bus.s_tvalid && (!w_full || w_pop);
  assign w_drop  = bus.s_tvalid && w_full && !w_pop;

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clears are written first so a same-cycle set from issue takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_br_pend <= '0;
    end else begin
      if (bus.wb_valid && is_reg(bus.wb_rd)) r_busy[bus.wb_warp_id][bus.wb_rd] <= 1'b0;
      if (w_pop && (w_head.flags[0] || w_head.flags[1]) && is_reg(w_head.rd))
        r_busy[w_head.warp][w_head.rd] <= 1'b1;
      if (bus.br_valid) r_br_pend[bus.br_warp_id] <= 1'b0;
      if (w_pop && w_head.flags[2]) r_br_pend[w_head.warp] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      if (w_drop) r_err[0] <= 1'b1;
      if (bus.wb_valid && is_reg(bus.wb_rd) && !r_busy[bus.wb_warp_id][bus.wb_rd])
        r_err[1] <= 1'b1;
      if (bus.br_valid && !r_br_pend[bus.br_warp_id]) r_err[2] <= 1'b1;
    end
  end

  assign bus.s_tready        = (r_count < (AW+1)'(DEPTH - 1));
  assign bus.m_tvalid        = w_valid;
  assign bus.m_tlast         = w_head.tlast;
  assign bus.m_warp_id       = w_head.warp;
  assign bus.m_rd            = w_head.rd;
  assign bus.m_rs1           = w_head.rs1;
  assign bus.m_rs2           = w_head.rs2;
  assign bus.m_opcode        = w_head.opcode;
  assign bus.m_imm           = w_head.imm;
  assign bus.m_feature_flags = w_head.flags;
  assign bus.err             = {29'd0, r_err};
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (DEPTH=4): inputs are driven and outputs
// sampled on the falling edge; expected values are hand-computed constants.
module tb_issue_scoreboard;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [5:0] exp_q[$];

  issue_scoreboard_if sif ();

  issue_scoreboard #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    sif.s_tvalid      = 1'b0;
    sif.s_tlast       = 1'b0;
    sif.warp_id_in    = '0;
    sif.rd            = '0;
    sif.rs1           = '0;
    sif.rs2           = '0;
    sif.opcode        = '0;
    sif.imm           = '0;
    sif.feature_flags = '0;
    sif.wb_valid      = 1'b0;
    sif.wb_warp_id    = '0;
    sif.wb_rd         = '0;
    sif.br_valid      = 1'b0;
    sif.br_warp_id    = '0;
  endtask

  task automatic set_beat(input logic [4:0] warp, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [7:0] op, input logic [7:0] flags,
                          input logic last, input logic [31:0] imm);
    sif.s_tvalid      = 1'b1;
    sif.warp_id_in    = warp;
    sif.rd            = rd;
    sif.rs1           = rs1;
    sif.rs2           = rs2;
    sif.opcode        = op;
    sif.feature_flags = flags;
    sif.s_tlast       = last;
    sif.imm           = imm;
  endtask

  task automatic send(input logic [4:0] warp, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [7:0] op, input logic [7:0] flags);
    set_beat(warp, rd, rs1, rs2, op, flags, 1'b0, 32'd0);
    cyc();
    sif.s_tvalid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] warp, input logic [4:0] rd);
    sif.wb_valid   = 1'b1;
    sif.wb_warp_id = warp;
    sif.wb_rd      = rd;
    cyc();
    sif.wb_valid   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr_in();
    sif.m_tready = 1'b0;
    repeat (2) cyc();

    chk("rst_m_tvalid", {31'd0, sif.m_tvalid}, 32'd0);
    chk("rst_s_tready", {31'd0, sif.s_tready}, 32'd1);
    chk("rst_m_opcode", {24'd0, sif.m_opcode}, 32'hff);
    chk("rst_m_rd", {27'd0, sif.m_rd}, 32'd0);
    chk("rst_m_imm", sif.m_imm, 32'd0);
    chk("rst_err", sif.err, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Back-to-back independent ops on warp 3
    sif.m_tready = 1'b1;
    set_beat(5'd3, 5'd5, 5'd1, 5'd2, 8'h33, 8'h01, 1'b0, 32'h11);
    cyc();
    chk("b2b_v0", {31'd0, sif.m_tvalid}, 32'd1);
    chk("b2b_rd0", {27'd0, sif.m_rd}, 32'd5);
    chk("b2b_warp0", {27'd0, sif.m_warp_id}, 32'd3);
    set_beat(5'd3, 5'd6, 5'd1, 5'd2, 8'h33, 8'h01, 1'b0, 32'h22);
    cyc();
    sif.s_tvalid = 1'b0;
    chk("b2b_v1", {31'd0, sif.m_tvalid}, 32'd1);
    chk("b2b_rd1", {27'd0, sif.m_rd}, 32'd6);
    chk("b2b_imm1", sif.m_imm, 32'h22);
    cyc();
    chk("b2b_empty", {31'd0, sif.m_tvalid}, 32'd0);
    chk("b2b_empty_op", {24'd0, sif.m_opcode}, 32'hff);

    // RAW on warp 3 rd 5
    send(5'd3, 5'd7, 5'd5, 5'd0, 8'h33, 8'h01);
    chk("raw_stall0", {31'd0, sif.m_tvalid}, 32'd0);
    cyc();
    chk("raw_stall1", {31'd0, sif.m_tvalid}, 32'd0);
    sif.wb_valid   = 1'b1;
    sif.wb_warp_id = 5'd3;
    sif.wb_rd      = 5'd5;
    #1;
`ifdef KIANA_SP_SCOREBOARD_BYPASS_EN
    chk("raw_wb_cycle", {31'd0, sif.m_tvalid}, 32'd1);
`else
    chk("raw_wb_cycle", {31'd0, sif.m_tvalid}, 32'd0);
`endif
    cyc();
    sif.wb_valid = 1'b0;
`ifndef KIANA_SP_SCOREBOARD_BYPASS_EN
    chk("raw_after_wb", {31'd0, sif.m_tvalid}, 32'd1);
    chk("raw_after_rd", {27'd0, sif.m_rd}, 32'd7);
    cyc();
`endif
    chk("raw_done", {31'd0, sif.m_tvalid}, 32'd0);
    chk("raw_err", sif.err, 32'd0);
    wb(5'd3, 5'd6);
    wb(5'd3, 5'd7);
    chk("busy_set_err", sif.err, 32'd0);

    // Branch gating on warp 2, warp 4 queued behind
    send(5'd2, 5'd0, 5'd0, 5'd0, 8'h63, 8'h3D);
    chk("br_issue", {31'd0, sif.m_tvalid}, 32'd1);
    cyc();
    set_beat(5'd2, 5'd8, 5'd1, 5'd0, 8'h33, 8'h01, 1'b0, 32'd0);
    cyc();
    set_beat(5'd4, 5'd9, 5'd0, 5'd0, 8'h33, 8'h01, 1'b0, 32'd0);
    cyc();
    sif.s_tvalid = 1'b0;
    chk("br_stall_v", {31'd0, sif.m_tvalid}, 32'd0);
    chk("br_stall_warp", {27'd0, sif.m_warp_id}, 32'd2);
    cyc();
    chk("br_block_v", {31'd0, sif.m_tvalid}, 32'd0);
    chk("br_block_rd", {27'd0, sif.m_rd}, 32'd8);
    sif.br_valid   = 1'b1;
    sif.br_warp_id = 5'd2;
    #1;
`ifdef KIANA_SP_SCOREBOARD_BYPASS_EN
    chk("br_res_cycle", {31'd0, sif.m_tvalid}, 32'd1);
`else
    chk("br_res_cycle", {31'd0, sif.m_tvalid}, 32'd0);
`endif
    cyc();
    sif.br_valid = 1'b0;
`ifndef KIANA_SP_SCOREBOARD_BYPASS_EN
    chk("br_after_v", {31'd0, sif.m_tvalid}, 32'd1);
    chk("br_after_rd", {27'd0, sif.m_rd}, 32'd8);
    cyc();
`endif
    chk("w4_v", {31'd0, sif.m_tvalid}, 32'd1);
    chk("w4_warp", {27'd0, sif.m_warp_id}, 32'd4);
    cyc();
    chk("br_err_clean", sif.err, 32'd0);
    sif.br_valid   = 1'b1;
    sif.br_warp_id = 5'd2;
    cyc();
    sif.br_valid = 1'b0;
    chk("br_err2", sif.err, 32'd4);
    wb(5'd2, 5'd8);
    wb(5'd4, 5'd9);
    chk("br_wb_err", sif.err, 32'd4);

    // Registers 0 and 31 are not operands
    send(5'd0, 5'd31, 5'd0, 5'd0, 8'h33, 8'h01);
    chk("r31_issue", {31'd0, sif.m_tvalid}, 32'd1);
    cyc();
    send(5'd0, 5'd0, 5'd0, 5'd0, 8'h33, 8'h01);
    chk("r0_issue", {31'd0, sif.m_tvalid}, 32'd1);
    cyc();
    send(5'd0, 5'd31, 5'd31, 5'd0, 8'h33, 8'h01);
    chk("r31_no_hazard", {31'd0, sif.m_tvalid}, 32'd1);
    cyc();
    wb(5'd0, 5'd31);
    chk("wb_r31_err", sif.err, 32'd4);
    wb(5'd0, 5'd7);
    chk("wb_nonbusy_err", sif.err, 32'd6);

    // Fill with m_tready low; fifth beat dropped
    sif.m_tready = 1'b0;
    chk("fill_rdy0", {31'd0, sif.s_tready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_beat(5'd1, 5'(11 + i), 5'd0, 5'd0, 8'h33, 8'h00, (i == 3), 32'(100 + i));
      if (i < 4) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, 5'(11 + i)});
      cyc();
      chk($sformatf("fill_rdy%0d", i + 1), {31'd0, sif.s_tready}, (i < 2) ? 32'd1 : 32'd0);
    end
    sif.s_tvalid = 1'b0;
    chk("fill_drop_err", sif.err, 32'd7);
    chk("fill_hold_v", {31'd0, sif.m_tvalid}, 32'd1);
    chk("fill_hold_rd", {27'd0, sif.m_rd}, 32'd11);
    sif.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      chk($sformatf("drain_v%0d", i), {31'd0, sif.m_tvalid}, 32'd1);
      chk($sformatf("drain_rd%0d", i), {27'd0, sif.m_rd}, {27'd0, e[4:0]});
      chk($sformatf("drain_last%0d", i), {31'd0, sif.m_tlast}, {31'd0, e[5]});
      chk($sformatf("drain_imm%0d", i), sif.m_imm, 32'(100 + i));
      cyc();
    end
    chk("drain_empty", {31'd0, sif.m_tvalid}, 32'd0);

    // Reset mid-operation
    send(5'd5, 5'd12, 5'd0, 5'd0, 8'h33, 8'h01);
    chk("pre_rst_issue", {31'd0, sif.m_tvalid}, 32'd1);
    cyc();
    sif.m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(5'd5, 5'd0, 5'd12, 5'd0, 8'h33, 8'h00, 1'b0, 32'd0);
      cyc();
    end
    sif.s_tvalid = 1'b0;
    chk("pre_rst_stall", {31'd0, sif.m_tvalid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", {31'd0, sif.m_tvalid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, sif.s_tready}, 32'd1);
    chk("mid_rst_err", sif.err, 32'd0);
    chk("mid_rst_op", {24'd0, sif.m_opcode}, 32'hff);
    cyc();
    rst_n = 1'b1;
    sif.m_tready = 1'b1;
    cyc();
    chk("post_rst_v", {31'd0, sif.m_tvalid}, 32'd0);
    send(5'd5, 5'd0, 5'd12, 5'd0, 8'h33, 8'h00);
    chk("post_rst_issue", {31'd0, sif.m_tvalid}, 32'd1);
    chk("post_rst_rs1", {27'd0, sif.m_rs1}, 32'd12);
    cyc();
    chk("post_rst_empty", {31'd0, sif.m_tvalid}, 32'd0);
    chk("post_rst_err", sif.err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
